// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the requesting masters, the round-robin arbiter and the shared slave.
// Handshake: a beat completes on a cycle where the granted wbm_stb_i and wbs_ack_i are both high.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int BYTE_EN_WIDTH  = BUS_DATA_WIDTH / 8
);
    logic [NUM_MASTERS-1:0]                wbm_cyc_i;
    logic [NUM_MASTERS-1:0]                wbm_stb_i;
    logic [NUM_MASTERS-1:0]                wbm_we_i;
    logic [NUM_MASTERS*BYTE_EN_WIDTH-1:0]  wbm_sel_i;
    logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0] wbm_adr_i;
    logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] wbm_dat_i;
    logic [BUS_DATA_WIDTH-1:0]             wbm_dat_o;
    logic [NUM_MASTERS-1:0]                wbm_ack_o;
    logic [NUM_MASTERS-1:0]                wbm_err_o;

    logic                                  wbs_cyc_o;
    logic                                  wbs_stb_o;
    logic                                  wbs_we_o;
    logic [BYTE_EN_WIDTH-1:0]              wbs_sel_o;
    logic [BUS_ADDR_WIDTH-1:0]             wbs_adr_o;
    logic [BUS_DATA_WIDTH-1:0]             wbs_dat_o;
    logic [BUS_DATA_WIDTH-1:0]             wbs_dat_i;
    logic                                  wbs_ack_i;

    // Arbiter view.
    modport slave (
        input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
        input  wbs_dat_i, wbs_ack_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
    );

    // Environment view: masters and slave model around the arbiter.
    modport master (
        output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
        output wbs_dat_i, wbs_ack_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one granted master per cyc period, combinational forward
// to the shared slave, and a stall timeout that answers a silent slave with err.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int BYTE_EN_WIDTH  = BUS_DATA_WIDTH / 8,
    parameter int TIMEOUT        = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_rr_arbiter_if.slave         bus,
    output logic [NUM_MASTERS-1:0] grant_o
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [NUM_MASTERS-1:0]  r_grant;
    logic [IDX_W-1:0]        r_last_idx;
    logic [CNT_W-1:0]        r_stall_cnt;

    logic                      w_busy;
    logic                      w_any_req;
    logic [IDX_W-1:0]          w_win_idx;
    logic                      w_sel_cyc;
    logic                      w_sel_stb;
    logic                      w_sel_we;
    logic [BYTE_EN_WIDTH-1:0]  w_sel_sel;
    logic [BUS_ADDR_WIDTH-1:0] w_sel_adr;
    logic [BUS_DATA_WIDTH-1:0] w_sel_dat;
    logic                      w_stall_max;
    logic                      w_ack_hit;
    logic                      w_expire;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
        return sum[IDX_W-1:0];
    endfunction

    // Scan from the farthest candidate down so the nearest requester after last grant wins.
    always_comb begin
        w_any_req = |bus.wbm_cyc_i;
        w_win_idx = r_last_idx;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (bus.wbm_cyc_i[rr_idx(r_last_idx, i)]) w_win_idx = rr_idx(r_last_idx, i);
        end
    end

    // r_last_idx doubles as the current owner while BUSY.
    always_comb begin
        w_sel_cyc = bus.wbm_cyc_i[r_last_idx];
        w_sel_stb = bus.wbm_stb_i[r_last_idx];
        w_sel_we  = bus.wbm_we_i[r_last_idx];
        w_sel_sel = bus.wbm_sel_i[int'(r_last_idx)*BYTE_EN_WIDTH +: BYTE_EN_WIDTH];
        w_sel_adr = bus.wbm_adr_i[int'(r_last_idx)*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
        w_sel_dat = bus.wbm_dat_i[int'(r_last_idx)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end

    assign w_busy      = (r_state == ST_BUSY);
    assign w_stall_max = (r_stall_cnt == CNT_W'(TIMEOUT - 1));
    // A reset cycle never completes or errors a beat.
    assign w_ack_hit   = w_busy & w_sel_stb & bus.wbs_ack_i & ~wb_rst_i;
    assign w_expire    = w_busy & w_sel_stb & ~bus.wbs_ack_i & w_stall_max & ~wb_rst_i;

    assign bus.wbs_cyc_o = w_busy & w_sel_cyc;
    assign bus.wbs_stb_o = w_busy & w_sel_stb;
    assign bus.wbs_we_o  = w_busy & w_sel_we;
    assign bus.wbs_sel_o = w_busy ? w_sel_sel : '0;
    assign bus.wbs_adr_o = w_busy ? w_sel_adr : '0;
    assign bus.wbs_dat_o = w_busy ? w_sel_dat : '0;

    assign bus.wbm_dat_o = bus.wbs_dat_i;
    assign bus.wbm_ack_o = w_ack_hit ? r_grant : '0;
    assign bus.wbm_err_o = w_expire  ? r_grant : '0;
    assign grant_o       = r_grant;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_last_idx  <= IDX_W'(NUM_MASTERS - 1);
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stall_cnt <= '0;
                    if (w_any_req) begin
                        r_state    <= ST_BUSY;
                        r_last_idx <= w_win_idx;
                        r_grant    <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win_idx;
                    end
                end
                ST_BUSY: begin
                    if (!w_sel_cyc) begin
                        // Releasing to IDLE enforces the dead cycle before any re-grant.
                        r_state     <= ST_IDLE;
                        r_grant     <= '0;
                        r_stall_cnt <= '0;
                    end else if (w_sel_stb && !bus.wbs_ack_i) begin
                        r_stall_cnt <= w_stall_max ? '0 : r_stall_cnt + 1'b1;
                    end else begin
                        r_stall_cnt <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_grant     <= '0;
                    r_stall_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one Wishbone slave port (e.g. a sw_reg_wr instance or a slave decode segment) between NUM_MASTERS requesting masters.
- Grants one master per bus cycle (cyc high period), forwards its signals to the slave, routes ack/data back, and terminates stalled cycles with a timeout error.
- Sits between master-side logic (CPU bridge, DMA, debug) and the slave bus, in the wb_clk_i domain.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- BUS_DATA_WIDTH, 32, data width (8, 16, 32, 64)
- BUS_ADDR_WIDTH, 8, address width (4, 8, 16, 32)
- BYTE_EN_WIDTH, BUS_DATA_WIDTH/8, byte-select width
- TIMEOUT, 16, stb-without-ack cycles before error (>=2)

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  synchronous reset, active high
- wbm_cyc_i  in  NUM_MASTERS  per-master cyc
- wbm_stb_i  in  NUM_MASTERS  per-master stb
- wbm_we_i  in  NUM_MASTERS  per-master write enable
- wbm_sel_i  in  NUM_MASTERS*BYTE_EN_WIDTH  packed byte selects, master k at [k*BE +: BE]
- wbm_adr_i  in  NUM_MASTERS*BUS_ADDR_WIDTH  packed addresses
- wbm_dat_i  in  NUM_MASTERS*BUS_DATA_WIDTH  packed write data
- wbm_dat_o  out  BUS_DATA_WIDTH  read data, broadcast to all masters
- wbm_ack_o  out  NUM_MASTERS  per-master ack
- wbm_err_o  out  NUM_MASTERS  per-master timeout error
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  to slave
- wbs_sel_o  out  BYTE_EN_WIDTH  to slave
- wbs_adr_o  out  BUS_ADDR_WIDTH  to slave
- wbs_dat_o  out  BUS_DATA_WIDTH  to slave
- wbs_dat_i  in  BUS_DATA_WIDTH  from slave
- wbs_ack_i  in  1  from slave
- grant_o  out  NUM_MASTERS  one-hot current grant (debug/status)

Behaviour:
- Reset: state=IDLE, grant_o=0, last_grant=NUM_MASTERS-1 (master 0 has top priority after reset), timeout counter=0.
- While IDLE, wbs_cyc_o/stb_o/we_o=0, sel/adr/dat_o=0, all wbm_ack_o/err_o=0.
- wbm_dat_o = wbs_dat_i at all times.
- Reset mid-cycle drops the grant and slave outputs on the next edge, with no ack/err issued.
- States: IDLE, BUSY.
- IDLE -> BUSY on the first edge where any wbm_cyc_i is high.
  - Winner is the first requester scanning last_grant+1, +2, ... with modulo NUM_MASTERS wrap.
  - grant_o and last_grant are registered.
  - Arbitration latency is 1 cycle; the slave sees cyc/stb the cycle after the request at the earliest.
- BUSY: slave outputs are a combinational mux of the granted master's inputs.
  - wbm_ack_o[g] = wbs_ack_i & wbm_stb_i[g]; other masters' ack is 0.
  - Multiple stb/ack beats are allowed within one cyc (block cycles hold the grant).
- BUSY -> IDLE on the edge where granted wbm_cyc_i is low.
  - That cycle, wbs_cyc_o is already low (combinational forward).
  - One dead IDLE cycle is mandatory before the next grant, including re-grant to the same master.
- Non-granted masters' requests are ignored (no ack, no err) until they win.
- Timeout: the counter increments each BUSY cycle with wbs_stb_o=1 and wbs_ack_i=0. It clears on ack, on stb low, or in IDLE.
  - When the count equals TIMEOUT-1 and the slave still gives no ack, wbm_err_o[g] pulses for 1 cycle and the counter clears.
  - Ack in the same cycle as expiry wins: ack is given, no err.
  - The master must drop or retry; the grant persists while cyc is held.
- Simultaneous requests: pure round-robin, no starvation. With N requesters continuously active, each is granted within N grants.

Test Plan:
- Single master: after reset, M0 writes adr 8'h00, dat 32'hEEEEEEEE, sel 4'hF, to a slave acking 1 cycle after stb.
  -> grant_o=2'b01 one cycle after cyc; wbs_dat_o=32'hEEEEEEEE; wbm_ack_o=2'b01 for 1 cycle.
- Contention: M0 and M1 raise cyc the same cycle after reset.
  -> M0 granted first. After M0 drops cyc, 1 idle cycle, then grant_o=2'b10 and M1 completes.
  -> The next simultaneous request grants M0 again.
- Read routing: M1 reads adr 8'h04 while the slave returns 32'hEE00EE00.
  -> wbm_dat_o=32'hEE00EE00 with wbm_ack_o=2'b10; wbm_ack_o[0] stays 0 throughout.
- Timeout: slave never acks, TIMEOUT=16, M0 holds stb.
  -> wbm_err_o[0] pulses on the 16th stb cycle, and again 16 cycles later if stb is still held. M1 receives no err.
- Ack at expiry: slave acks on exactly the 16th stb cycle.
  -> ack asserted, err stays 0.
- Reset mid-cycle: assert wb_rst_i during M1's BUSY.
  -> next edge grant_o=0, wbs_cyc_o=0. Then simultaneous M0/M1 requests grant M0.
